// File: rtl/tlb_ctrl_if.sv
// Signal bundle between the TLB control core, the processor, the page-table walker
// and the external entry storage array.
interface tlb_ctrl_if #(
  parameter int unsigned NUM_WAYS       = 4,
  parameter int unsigned SET_INDEX_BITS = 4,
  parameter int unsigned LRU_BITS       = 2
) ();
  logic                           req_valid_i;
  logic                           req_ready_o;
  logic [31:0]                    vaddr_i;
  logic                           access_type_i;
  logic                           resp_valid_o;
  logic                           resp_ready_i;
  logic [31:0]                    paddr_o;
  logic                           hit_o;
  logic                           fault_o;
  logic                           ptw_req_valid_o;
  logic                           ptw_req_ready_i;
  logic [31:0]                    ptw_vaddr_o;
  logic                           ptw_resp_valid_i;
  logic                           ptw_resp_ready_o;
  logic [31:0]                    ptw_pte_i;
  logic [SET_INDEX_BITS-1:0]      set_index_o;
  logic [NUM_WAYS-1:0]            rd_valid_i;
  logic [20*NUM_WAYS-1:0]         rd_vpn_i;
  logic [20*NUM_WAYS-1:0]         rd_ppn_i;
  logic [2*NUM_WAYS-1:0]          rd_perms_i;
  logic [LRU_BITS*NUM_WAYS-1:0]   rd_lru_i;
  logic                           wr_en_o;
  logic [1:0]                     wr_way_o;
  logic [19:0]                    wr_vpn_o;
  logic [19:0]                    wr_ppn_o;
  logic [1:0]                     wr_perms_o;
  logic                           lru_update_en_o;
  logic [1:0]                     lru_way_o;

  // Processor / walker / storage side
  modport master (
    output req_valid_i, vaddr_i, access_type_i, resp_ready_i,
    output ptw_req_ready_i, ptw_resp_valid_i, ptw_pte_i,
    output rd_valid_i, rd_vpn_i, rd_ppn_i, rd_perms_i, rd_lru_i,
    input  req_ready_o, resp_valid_o, paddr_o, hit_o, fault_o,
    input  ptw_req_valid_o, ptw_vaddr_o, ptw_resp_ready_o, set_index_o,
    input  wr_en_o, wr_way_o, wr_vpn_o, wr_ppn_o, wr_perms_o,
    input  lru_update_en_o, lru_way_o
  );

  // Control core side
  modport slave (
    input  req_valid_i, vaddr_i, access_type_i, resp_ready_i,
    input  ptw_req_ready_i, ptw_resp_valid_i, ptw_pte_i,
    input  rd_valid_i, rd_vpn_i, rd_ppn_i, rd_perms_i, rd_lru_i,
    output req_ready_o, resp_valid_o, paddr_o, hit_o, fault_o,
    output ptw_req_valid_o, ptw_vaddr_o, ptw_resp_ready_o, set_index_o,
    output wr_en_o, wr_way_o, wr_vpn_o, wr_ppn_o, wr_perms_o,
    output lru_update_en_o, lru_way_o
  );
endinterface

// File: rtl/tlb_ctrl_core.sv
// Lookup, page-table-walk sequencing and replacement control for a 4-way set-associative TLB.
// Entry storage lives outside; this core reads the indexed set and emits write/LRU strobes.
module tlb_ctrl_core #(
  parameter int unsigned NUM_WAYS       = 4,
  parameter int unsigned SET_INDEX_BITS = 4,
  parameter int unsigned LRU_BITS       = 2
) (
  input logic      clk,
  input logic      rst,
  tlb_ctrl_if.slave bus
);
  localparam int unsigned WAY_BITS = 2;
  localparam int unsigned TAG_BITS = 20;

  typedef enum logic [2:0] {
    ACCEPT_REQ  = 3'd0,
    LOOKUP      = 3'd1,
    PTW_REQ     = 3'd2,
    PTW_PENDING = 3'd3,
    UPDATE      = 3'd4,
    RESPOND     = 3'd5
  } state_t;

  state_t        state, state_next;
  logic [31:0]   vaddr_reg, vaddr_next;
  logic          access_reg, access_next;
  logic [31:0]   pte_reg, pte_next;
  logic [31:0]   paddr_q, paddr_next;
  logic          hit_q, hit_next;
  logic          fault_q, fault_next;
  logic [31:0]   ptw_vaddr_q, ptw_vaddr_next;
  logic          wr_en, lru_en;

  logic [19:0]   vpn;
  logic [11:0]   offset;
  logic          hit_any;
  logic [WAY_BITS-1:0] hit_way;
  logic [19:0]   hit_ppn;
  logic [1:0]    hit_perms;
  logic          lookup_fault;
  logic          pte_fault;
  logic          unused_pte;

  logic          inv_found;
  logic [WAY_BITS-1:0] inv_way;
  logic [WAY_BITS-1:0] old_way;
  logic [LRU_BITS-1:0] old_age;
  logic [WAY_BITS-1:0] replace_way;

  assign vpn        = vaddr_reg[31:12];
  assign offset     = vaddr_reg[11:0];
  assign unused_pte = ^pte_reg[11:3];

  // Tag match across the set; the lowest matching way wins
  always_comb begin
    hit_any   = 1'b0;
    hit_way   = '0;
    hit_ppn   = '0;
    hit_perms = '0;
    for (int i = 0; i < int'(NUM_WAYS); i++) begin
      if (!hit_any && bus.rd_valid_i[i] && (bus.rd_vpn_i[i*TAG_BITS +: TAG_BITS] == vpn)) begin
        hit_any   = 1'b1;
        hit_way   = WAY_BITS'(i);
        hit_ppn   = bus.rd_ppn_i[i*TAG_BITS +: TAG_BITS];
        hit_perms = bus.rd_perms_i[i*2 +: 2];
      end
    end
  end

  assign lookup_fault = access_reg ? !hit_perms[1] : !hit_perms[0];
  assign pte_fault    = access_reg ? !pte_reg[2]   : !pte_reg[1];

  // Victim: first invalid way, else the oldest way (strict compare keeps the lowest on ties)
  always_comb begin
    inv_found = 1'b0;
    inv_way   = '0;
    old_way   = '0;
    old_age   = bus.rd_lru_i[LRU_BITS-1:0];
    for (int i = 0; i < int'(NUM_WAYS); i++) begin
      if (!inv_found && !bus.rd_valid_i[i]) begin
        inv_found = 1'b1;
        inv_way   = WAY_BITS'(i);
      end
      if (bus.rd_lru_i[i*LRU_BITS +: LRU_BITS] > old_age) begin
        old_age = bus.rd_lru_i[i*LRU_BITS +: LRU_BITS];
        old_way = WAY_BITS'(i);
      end
    end
    replace_way = inv_found ? inv_way : old_way;
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ACCEPT_REQ;
      vaddr_reg   <= '0;
      access_reg  <= 1'b0;
      pte_reg     <= '0;
      paddr_q     <= '0;
      hit_q       <= 1'b0;
      fault_q     <= 1'b0;
      ptw_vaddr_q <= '0;
    end else begin
      state       <= state_next;
      vaddr_reg   <= vaddr_next;
      access_reg  <= access_next;
      pte_reg     <= pte_next;
      paddr_q     <= paddr_next;
      hit_q       <= hit_next;
      fault_q     <= fault_next;
      ptw_vaddr_q <= ptw_vaddr_next;
    end
  end

  // Next state, next datapath values and single-cycle strobes
  always_comb begin
    state_next     = state;
    vaddr_next     = vaddr_reg;
    access_next    = access_reg;
    pte_next       = pte_reg;
    paddr_next     = paddr_q;
    hit_next       = hit_q;
    fault_next     = fault_q;
    ptw_vaddr_next = ptw_vaddr_q;
    wr_en          = 1'b0;
    lru_en         = 1'b0;
    case (state)
      ACCEPT_REQ: begin
        if (bus.req_valid_i) begin
          vaddr_next  = bus.vaddr_i;
          access_next = bus.access_type_i;
          state_next  = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit_any) begin
          hit_next   = 1'b1;
          state_next = RESPOND;
          if (lookup_fault) begin
            paddr_next = '0;
            fault_next = 1'b1;
          end else begin
            paddr_next = {hit_ppn, offset};
            fault_next = 1'b0;
            lru_en     = 1'b1;
          end
        end else begin
          ptw_vaddr_next = vaddr_reg;
          state_next     = PTW_REQ;
        end
      end
      PTW_REQ: begin
        if (bus.ptw_req_ready_i) state_next = PTW_PENDING;
      end
      PTW_PENDING: begin
        if (bus.ptw_resp_valid_i) begin
          pte_next   = bus.ptw_pte_i;
          state_next = UPDATE;
        end
      end
      UPDATE: begin
        state_next = RESPOND;
        if (!pte_reg[0]) begin
          paddr_next = '0;
          hit_next   = 1'b0;
          fault_next = 1'b1;
        end else if (pte_fault) begin
          paddr_next = '0;
          hit_next   = 1'b1;
          fault_next = 1'b1;
        end else begin
          paddr_next = {pte_reg[31:12], offset};
          hit_next   = 1'b1;
          fault_next = 1'b0;
          wr_en      = 1'b1;
        end
      end
      RESPOND: begin
        if (bus.resp_ready_i) begin
          paddr_next = '0;
          hit_next   = 1'b0;
          fault_next = 1'b0;
          state_next = ACCEPT_REQ;
        end
      end
      default: state_next = ACCEPT_REQ;
    endcase
  end

  assign bus.req_ready_o      = (state == ACCEPT_REQ);
  assign bus.ptw_req_valid_o  = (state == PTW_REQ);
  assign bus.ptw_resp_ready_o = (state == PTW_PENDING);
  assign bus.resp_valid_o     = (state == RESPOND);
  assign bus.paddr_o          = paddr_q;
  assign bus.hit_o            = hit_q;
  assign bus.fault_o          = fault_q;
  assign bus.ptw_vaddr_o      = ptw_vaddr_q;
  assign bus.set_index_o      = vaddr_reg[12 +: SET_INDEX_BITS];
  assign bus.wr_en_o          = wr_en;
  assign bus.wr_way_o         = replace_way;
  assign bus.wr_vpn_o         = vpn;
  assign bus.wr_ppn_o         = pte_reg[31:12];
  assign bus.wr_perms_o       = pte_reg[2:1];
  assign bus.lru_update_en_o  = lru_en;
  assign bus.lru_way_o        = hit_way;
endmodule

// File: tb/tb_tlb_ctrl_core.sv
// Directed bench for tlb_ctrl_core: hits, permission faults, PTW fills, replacement,
// response back-pressure and asynchronous reset.
module tb_tlb_ctrl_core;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  tlb_ctrl_if #(.NUM_WAYS(4), .SET_INDEX_BITS(4), .LRU_BITS(2)) bus ();

  tlb_ctrl_core #(.NUM_WAYS(4), .SET_INDEX_BITS(4), .LRU_BITS(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observations of the most recent transaction
  logic [31:0] obs_paddr, obs_ptw_vaddr, post_paddr;
  logic        obs_hit, obs_fault, obs_stable, obs_timeout, post_hit, post_fault, post_req_ready;
  logic [3:0]  obs_set_idx;
  logic [1:0]  obs_lru_way, obs_wr_way, obs_wr_perms;
  logic [19:0] obs_wr_vpn, obs_wr_ppn;
  int          obs_lru_cnt, obs_wr_cnt, obs_ptw_cnt;

  task automatic clear_storage();
    bus.rd_valid_i = '0;
    bus.rd_vpn_i   = '0;
    bus.rd_ppn_i   = '0;
    bus.rd_perms_i = '0;
    bus.rd_lru_i   = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one request through the core, playing the walker and the processor
  task automatic run_txn(input logic [31:0] va, input logic acc, input int ptw_delay,
                         input logic [31:0] pte, input int resp_hold);
    int guard;
    int stalls;
    obs_lru_cnt = 0; obs_wr_cnt = 0; obs_ptw_cnt = 0; obs_lru_way = '0;
    obs_wr_way = '0; obs_wr_vpn = '0; obs_wr_ppn = '0; obs_wr_perms = '0;
    obs_ptw_vaddr = '0; obs_stable = 1'b1; obs_timeout = 1'b0;
    guard = 0;
    while (!bus.req_ready_o && guard < 50) begin step(); guard++; end
    bus.req_valid_i = 1'b1; bus.vaddr_i = va; bus.access_type_i = acc;
    step();
    bus.req_valid_i = 1'b0; bus.vaddr_i = 32'hDEAD_BEEF; bus.access_type_i = ~acc;
    obs_set_idx = bus.set_index_o;
    guard = 0; stalls = 0;
    while (!bus.resp_valid_o && guard < 200) begin
      if (bus.lru_update_en_o) begin obs_lru_cnt++; obs_lru_way = bus.lru_way_o; end
      if (bus.wr_en_o) begin
        obs_wr_cnt++; obs_wr_way = bus.wr_way_o; obs_wr_vpn = bus.wr_vpn_o;
        obs_wr_ppn = bus.wr_ppn_o; obs_wr_perms = bus.wr_perms_o;
      end
      if (bus.ptw_req_valid_o) begin
        obs_ptw_cnt++; obs_ptw_vaddr = bus.ptw_vaddr_o;
        bus.ptw_req_ready_i = (stalls >= ptw_delay); stalls++;
      end else bus.ptw_req_ready_i = 1'b0;
      if (bus.ptw_resp_ready_o) begin bus.ptw_resp_valid_i = 1'b1; bus.ptw_pte_i = pte; end
      else begin bus.ptw_resp_valid_i = 1'b0; bus.ptw_pte_i = 32'hFFFF_FFFF; end
      step(); guard++;
    end
    bus.ptw_req_ready_i = 1'b0; bus.ptw_resp_valid_i = 1'b0;
    obs_timeout = !bus.resp_valid_o;
    obs_paddr = bus.paddr_o; obs_hit = bus.hit_o; obs_fault = bus.fault_o;
    for (int k = 0; k < resp_hold; k++) begin
      step();
      if (!bus.resp_valid_o || bus.paddr_o !== obs_paddr || bus.hit_o !== obs_hit ||
          bus.fault_o !== obs_fault || bus.wr_en_o || bus.lru_update_en_o) obs_stable = 1'b0;
    end
    bus.resp_ready_i = 1'b1;
    step();
    bus.resp_ready_i = 1'b0;
    post_paddr = bus.paddr_o; post_hit = bus.hit_o; post_fault = bus.fault_o;
    post_req_ready = bus.req_ready_o;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2;
    checks++; if (bus.req_ready_o !== 1'b1) begin errors++; $display("FAIL reset req_ready got %b exp 1", bus.req_ready_o); end
    checks++; if ({bus.resp_valid_o, bus.ptw_req_valid_o, bus.ptw_resp_ready_o} !== 3'b000) begin errors++; $display("FAIL reset handshakes got %b exp 000", {bus.resp_valid_o, bus.ptw_req_valid_o, bus.ptw_resp_ready_o}); end
    checks++; if ({bus.paddr_o, bus.ptw_vaddr_o, bus.hit_o, bus.fault_o, bus.wr_en_o, bus.lru_update_en_o} !== 68'h0) begin errors++; $display("FAIL reset outputs got paddr %h ptw %h hit %b fault %b", bus.paddr_o, bus.ptw_vaddr_o, bus.hit_o, bus.fault_o); end
    step(); step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_hit_read();
    clear_storage();
    bus.rd_valid_i[2] = 1'b1; bus.rd_vpn_i[40 +: 20] = 20'h12343;
    bus.rd_ppn_i[40 +: 20] = 20'h55555; bus.rd_perms_i[4 +: 2] = 2'b01;
    run_txn(32'h12343ABC, 1'b0, 0, 32'h0, 0);
    checks++; if (obs_timeout) begin errors++; $display("FAIL hit_read timeout got 1 exp 0"); end
    checks++; if (obs_set_idx !== 4'h3) begin errors++; $display("FAIL hit_read set_index got %h exp 3", obs_set_idx); end
    checks++; if (obs_paddr !== 32'h55555ABC) begin errors++; $display("FAIL hit_read paddr got %h exp 55555abc", obs_paddr); end
    checks++; if ({obs_hit, obs_fault} !== 2'b10) begin errors++; $display("FAIL hit_read hit/fault got %b exp 10", {obs_hit, obs_fault}); end
    checks++; if (obs_lru_cnt != 1 || obs_lru_way !== 2'd2) begin errors++; $display("FAIL hit_read lru pulses %0d way %0d exp 1 way 2", obs_lru_cnt, obs_lru_way); end
    checks++; if (obs_ptw_cnt != 0 || obs_wr_cnt != 0) begin errors++; $display("FAIL hit_read ptw %0d wr %0d exp 0 0", obs_ptw_cnt, obs_wr_cnt); end
  endtask

  task automatic test_hit_write_fault();
    run_txn(32'h12343ABC, 1'b1, 0, 32'h0, 0);
    checks++; if (obs_paddr !== 32'h0) begin errors++; $display("FAIL hit_wfault paddr got %h exp 0", obs_paddr); end
    checks++; if ({obs_hit, obs_fault} !== 2'b11) begin errors++; $display("FAIL hit_wfault hit/fault got %b exp 11", {obs_hit, obs_fault}); end
    checks++; if (obs_lru_cnt != 0 || obs_ptw_cnt != 0) begin errors++; $display("FAIL hit_wfault lru %0d ptw %0d exp 0 0", obs_lru_cnt, obs_ptw_cnt); end
  endtask

  task automatic test_miss_fill();
    clear_storage();
    run_txn(32'h0000F123, 1'b0, 3, 32'hABCDE003, 0);
    checks++; if (obs_ptw_vaddr !== 32'h0000F123) begin errors++; $display("FAIL miss_fill ptw_vaddr got %h exp 0000f123", obs_ptw_vaddr); end
    checks++; if (obs_ptw_cnt != 4) begin errors++; $display("FAIL miss_fill ptw_valid cycles got %0d exp 4", obs_ptw_cnt); end
    checks++; if (obs_wr_cnt != 1 || obs_wr_way !== 2'd0) begin errors++; $display("FAIL miss_fill wr pulses %0d way %0d exp 1 way 0", obs_wr_cnt, obs_wr_way); end
    checks++; if ({obs_wr_vpn, obs_wr_ppn, obs_wr_perms} !== {20'h0000F, 20'hABCDE, 2'b01}) begin errors++; $display("FAIL miss_fill wr fields got %h %h %b exp 0000f abcde 01", obs_wr_vpn, obs_wr_ppn, obs_wr_perms); end
    checks++; if (obs_paddr !== 32'hABCDE123 || {obs_hit, obs_fault} !== 2'b10) begin errors++; $display("FAIL miss_fill resp got %h %b exp abcde123 10", obs_paddr, {obs_hit, obs_fault}); end
    checks++; if (obs_lru_cnt != 0) begin errors++; $display("FAIL miss_fill lru pulses got %0d exp 0", obs_lru_cnt); end
  endtask

  task automatic test_miss_faults();
    clear_storage();
    run_txn(32'h00001000, 1'b0, 0, 32'h00000000, 0);
    checks++; if (obs_paddr !== 32'h0 || {obs_hit, obs_fault} !== 2'b01) begin errors++; $display("FAIL pte_invalid resp got %h %b exp 0 01", obs_paddr, {obs_hit, obs_fault}); end
    checks++; if (obs_wr_cnt != 0 || obs_ptw_cnt != 1) begin errors++; $display("FAIL pte_invalid wr %0d ptw %0d exp 0 1", obs_wr_cnt, obs_ptw_cnt); end
    run_txn(32'h00002000, 1'b1, 0, 32'h12345003, 0);
    checks++; if (obs_paddr !== 32'h0 || {obs_hit, obs_fault} !== 2'b11) begin errors++; $display("FAIL pte_wfault resp got %h %b exp 0 11", obs_paddr, {obs_hit, obs_fault}); end
    checks++; if (obs_wr_cnt != 0) begin errors++; $display("FAIL pte_wfault wr pulses got %0d exp 0", obs_wr_cnt); end
  endtask

  task automatic test_lru_replace_and_hold();
    clear_storage();
    bus.rd_valid_i = 4'hF;
    bus.rd_vpn_i   = {20'hAAAA3, 20'hAAAA2, 20'hAAAA1, 20'hAAAA0};
    bus.rd_lru_i   = 8'b00_11_11_01;
    run_txn(32'h00099456, 1'b0, 0, 32'h00077007, 4);
    checks++; if (obs_wr_cnt != 1 || obs_wr_way !== 2'd1) begin errors++; $display("FAIL lru_victim wr pulses %0d way %0d exp 1 way 1", obs_wr_cnt, obs_wr_way); end
    checks++; if (obs_wr_perms !== 2'b11 || obs_paddr !== 32'h00077456) begin errors++; $display("FAIL lru_fill perms %b paddr %h exp 11 00077456", obs_wr_perms, obs_paddr); end
    checks++; if (!obs_stable) begin errors++; $display("FAIL resp_hold stable got 0 exp 1"); end
    checks++; if ({post_paddr, post_hit, post_fault} !== 34'h0) begin errors++; $display("FAIL resp_clear got %h %b %b exp 0", post_paddr, post_hit, post_fault); end
    checks++; if (post_req_ready !== 1'b1) begin errors++; $display("FAIL resp_clear req_ready got %b exp 1", post_req_ready); end
  endtask

  task automatic test_multi_hit();
    clear_storage();
    bus.rd_valid_i = 4'b1010;
    bus.rd_vpn_i   = {20'h00A55, 20'h0, 20'h00A55, 20'h0};
    bus.rd_ppn_i   = {20'h33333, 20'h0, 20'h11111, 20'h0};
    bus.rd_perms_i = 8'hFF;
    run_txn(32'h00A55010, 1'b1, 0, 32'h0, 0);
    checks++; if (obs_paddr !== 32'h11111010 || {obs_hit, obs_fault} !== 2'b10) begin errors++; $display("FAIL multi_hit resp got %h %b exp 11111010 10", obs_paddr, {obs_hit, obs_fault}); end
    checks++; if (obs_lru_cnt != 1 || obs_lru_way !== 2'd1 || obs_set_idx !== 4'h5) begin errors++; $display("FAIL multi_hit lru %0d way %0d set %h exp 1 1 5", obs_lru_cnt, obs_lru_way, obs_set_idx); end
  endtask

  task automatic test_reset_mid_ptw();
    int guard;
    clear_storage();
    guard = 0;
    while (!bus.req_ready_o && guard < 50) begin step(); guard++; end
    bus.req_valid_i = 1'b1; bus.vaddr_i = 32'h00042777; bus.access_type_i = 1'b0;
    step();
    bus.req_valid_i = 1'b0;
    guard = 0;
    while (!bus.ptw_resp_ready_o && guard < 50) begin
      bus.ptw_req_ready_i = bus.ptw_req_valid_o;
      step(); guard++;
    end
    bus.ptw_req_ready_i = 1'b0;
    checks++; if (bus.ptw_resp_ready_o !== 1'b1) begin errors++; $display("FAIL rst_mid reach_pending got %b exp 1", bus.ptw_resp_ready_o); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (bus.req_ready_o !== 1'b1 || bus.ptw_resp_ready_o !== 1'b0) begin errors++; $display("FAIL rst_mid handshakes req_ready %b ptw_resp_ready %b exp 1 0", bus.req_ready_o, bus.ptw_resp_ready_o); end
    checks++; if ({bus.paddr_o, bus.ptw_vaddr_o, bus.hit_o, bus.fault_o, bus.wr_en_o, bus.lru_update_en_o, bus.resp_valid_o} !== 69'h0) begin errors++; $display("FAIL rst_mid outputs paddr %h ptw %h exp 0", bus.paddr_o, bus.ptw_vaddr_o); end
    step();
    rst = 1'b1;
    step();
  endtask

  initial begin
    checks = 0; errors = 0;
    bus.req_valid_i = 1'b0; bus.vaddr_i = '0; bus.access_type_i = 1'b0;
    bus.resp_ready_i = 1'b0; bus.ptw_req_ready_i = 1'b0; bus.ptw_resp_valid_i = 1'b0;
    bus.ptw_pte_i = '0;
    clear_storage();
    test_reset();
    test_hit_read();
    test_hit_write_fault();
    test_miss_fill();
    test_miss_faults();
    test_lru_replace_and_hold();
    test_multi_hit();
    test_reset_mid_ptw();
    test_hit_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
